// File: rtl/m1_pkg.sv
// Shared encoder definitions: SRAM map, FSM states, pixel types and BT.601 fixed-point helpers.
package m1_pkg;

    localparam logic [17:0] RGB_BASE     = 18'd146944;
    localparam logic [17:0] Y_BASE       = 18'd0;
    localparam logic [17:0] U_BASE       = 18'd38400;
    localparam logic [17:0] V_BASE       = 18'd57600;
    localparam int          FRAME_GROUPS = 19200;
    localparam int          GRP_W        = 15;

    localparam logic signed [17:0] C_YR =  18'sd16829;
    localparam logic signed [17:0] C_YG =  18'sd33039;
    localparam logic signed [17:0] C_YB =  18'sd6416;
    localparam logic signed [17:0] C_UR = -18'sd9714;
    localparam logic signed [17:0] C_UG = -18'sd19070;
    localparam logic signed [17:0] C_UB =  18'sd28784;
    localparam logic signed [17:0] C_VR =  18'sd28784;
    localparam logic signed [17:0] C_VG = -18'sd24103;
    localparam logic signed [17:0] C_VB = -18'sd4681;

    typedef enum logic [3:0] {
        IDLE, G0, G1, G2, G3, G4, G5, G6, G7, G8, G9, G10, G11
    } enc_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] u;
        logic [7:0] v;
    } yuv_t;

    // offset + round(c . rgb) >>> 16, clipped to one byte
    function automatic logic [7:0] csc_term(input logic signed [31:0] offset,
                                            input logic signed [17:0] c_r,
                                            input logic signed [17:0] c_g,
                                            input logic signed [17:0] c_b,
                                            input rgb_t p);
        logic signed [31:0] acc;
        logic [7:0]         res;
        acc = 32'(c_r) * $signed({24'd0, p.r})
            + 32'(c_g) * $signed({24'd0, p.g})
            + 32'(c_b) * $signed({24'd0, p.b})
            + 32'sd32768;
        acc = offset + (acc >>> 16);
        if (acc < 32'sd0)        res = 8'd0;
        else if (acc > 32'sd255) res = 8'd255;
        else                     res = acc[7:0];
        return res;
    endfunction

    function automatic logic [7:0] avg2(input logic [7:0] a, input logic [7:0] b);
        return 8'(({1'b0, a} + {1'b0, b} + 9'd1) >> 1);
    endfunction

endpackage

// File: rtl/rgb_to_yuv_encoder_if.sv
// Single-port SRAM bus owned by the encoder while a frame is being converted.
interface rgb_to_yuv_encoder_if;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data;

    modport master (output SRAM_address, output SRAM_write_data, output SRAM_we_n,
                    input  SRAM_read_data);
    modport slave  (input  SRAM_address, input  SRAM_write_data, input  SRAM_we_n,
                    output SRAM_read_data);
endinterface

// File: rtl/rgb_to_yuv_csc.sv
// BT.601 colour-space converter: one pixel per cycle, registered YUV one cycle later.
module rgb_to_yuv_csc
    import m1_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  rgb_t pix,
    output yuv_t yuv
);

    always_ff @(posedge clk) begin
        if (rst) begin
            yuv <= '0;
        end else if (in_valid) begin
            yuv.y <= csc_term(32'sd16,  C_YR, C_YG, C_YB, pix);
            yuv.u <= csc_term(32'sd128, C_UR, C_UG, C_UB, pix);
            yuv.v <= csc_term(32'sd128, C_VR, C_VG, C_VB, pix);
        end
    end

endmodule

// File: rtl/rgb_to_yuv_encoder.sv
// Frame encoder: streams 4-pixel RGB groups from SRAM, converts, decimates chroma, writes Y/U/V back.
//   state    | meaning
//   IDLE     | waiting for enc_start
//   G0..G5   | read RGB words w0..w5
//   G6, G9   | write Y word for pixels 0/1, 2/3
//   G7, G8   | bus idle, pixels 2/3 enter the converter
//   G10, G11 | write U word, write V word, then next group or done
module rgb_to_yuv_encoder
    import m1_pkg::*;
#(
    parameter int GROUPS = FRAME_GROUPS
) (
    input  logic                 CLOCK_50_I,
    input  logic                 Reset,
    input  logic                 enc_start,
    output logic                 enc_done,
    rgb_to_yuv_encoder_if.master sram
);

    enc_state_t       state;
    logic [17:0]      rgb_ptr, y_ptr, u_ptr, v_ptr;
    logic [GRP_W-1:0] grp_left;
    rgb_t             pix [4];
    logic [7:0]       y_hold, u_hold, v_hold, u_a, v_a, u_b, v_b;
    logic             csc_valid;
    rgb_t             csc_in;
    yuv_t             csc_out;
    logic [15:0]      rd;

    assign rd = sram.SRAM_read_data;

    always_comb begin
        csc_valid = 1'b0;
        csc_in    = pix[0];
        case (state)
            G4:      begin csc_valid = 1'b1; csc_in = pix[0]; end
            G5:      begin csc_valid = 1'b1; csc_in = pix[1]; end
            G7:      begin csc_valid = 1'b1; csc_in = pix[2]; end
            G8:      begin csc_valid = 1'b1; csc_in = pix[3]; end
            default: ;
        endcase
    end

    rgb_to_yuv_csc u_csc (
        .clk      (CLOCK_50_I),
        .rst      (Reset),
        .in_valid (csc_valid),
        .pix      (csc_in),
        .yuv      (csc_out)
    );

    always_ff @(posedge CLOCK_50_I) begin
        if (Reset) begin
            state                <= IDLE;
            enc_done             <= 1'b0;
            sram.SRAM_address    <= '0;
            sram.SRAM_write_data <= '0;
            sram.SRAM_we_n       <= 1'b1;
            rgb_ptr              <= RGB_BASE;
            y_ptr                <= Y_BASE;
            u_ptr                <= U_BASE;
            v_ptr                <= V_BASE;
            grp_left             <= '0;
            pix                  <= '{default: '0};
            {y_hold, u_hold, v_hold, u_a, v_a, u_b, v_b} <= '0;
        end else begin
            enc_done       <= 1'b0;
            sram.SRAM_we_n <= 1'b1;

            // Reads: the word addressed in Gk is on the bus during Gk+2
            if (state inside {G0, G1, G2, G3, G4, G5}) begin
                sram.SRAM_address <= rgb_ptr;
                rgb_ptr           <= rgb_ptr + 18'd1;
            end

            case (state)
                IDLE: begin
                    if (enc_start) begin
                        rgb_ptr  <= RGB_BASE;
                        y_ptr    <= Y_BASE;
                        u_ptr    <= U_BASE;
                        v_ptr    <= V_BASE;
                        grp_left <= GRP_W'(GROUPS - 1);
                        state    <= G0;
                    end
                end
                G2: begin pix[0].r <= rd[15:8]; pix[0].g <= rd[7:0]; end
                G3: begin pix[0].b <= rd[15:8]; pix[1].r <= rd[7:0]; end
                G4: begin pix[1].g <= rd[15:8]; pix[1].b <= rd[7:0]; end
                G5: begin
                    pix[2].r <= rd[15:8];
                    pix[2].g <= rd[7:0];
                    {y_hold, u_hold, v_hold} <= csc_out;
                end
                G6: begin
                    pix[2].b             <= rd[15:8];
                    pix[3].r             <= rd[7:0];
                    sram.SRAM_address    <= y_ptr;
                    sram.SRAM_write_data <= {y_hold, csc_out.y};
                    sram.SRAM_we_n       <= 1'b0;
                    y_ptr                <= y_ptr + 18'd1;
                    u_a                  <= avg2(u_hold, csc_out.u);
                    v_a                  <= avg2(v_hold, csc_out.v);
                end
                G7: begin pix[3].g <= rd[15:8]; pix[3].b <= rd[7:0]; end
                G8: {y_hold, u_hold, v_hold} <= csc_out;
                G9: begin
                    sram.SRAM_address    <= y_ptr;
                    sram.SRAM_write_data <= {y_hold, csc_out.y};
                    sram.SRAM_we_n       <= 1'b0;
                    y_ptr                <= y_ptr + 18'd1;
                    u_b                  <= avg2(u_hold, csc_out.u);
                    v_b                  <= avg2(v_hold, csc_out.v);
                end
                G10: begin
                    sram.SRAM_address    <= u_ptr;
                    sram.SRAM_write_data <= {u_a, u_b};
                    sram.SRAM_we_n       <= 1'b0;
                    u_ptr                <= u_ptr + 18'd1;
                end
                G11: begin
                    sram.SRAM_address    <= v_ptr;
                    sram.SRAM_write_data <= {v_a, v_b};
                    sram.SRAM_we_n       <= 1'b0;
                    v_ptr                <= v_ptr + 18'd1;
                end
                default: ;
            endcase

            if (state == G11) begin
                if (grp_left != '0) begin
                    grp_left <= grp_left - 1'b1;
                    state    <= G0;
                end else begin
                    enc_done <= 1'b1;
                    state    <= IDLE;
                end
            end else if (state != IDLE) begin
                state <= enc_state_t'(state + 4'd1);
            end
        end
    end

endmodule

// File: tb/tb_rgb_to_yuv_encoder.sv
// Encoder bench: SRAM model, random frame with directed leading groups, abort/restart and reset checks.
module tb_rgb_to_yuv_encoder;

    localparam int NG    = 1000;
    localparam int RGB_B = 146944;
    localparam int Y_B   = 0;
    localparam int U_B   = 38400;
    localparam int V_B   = 57600;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic done;

    rgb_to_yuv_encoder_if sram_bus ();

    rgb_to_yuv_encoder #(.GROUPS(NG)) dut (
        .CLOCK_50_I (clk),
        .Reset      (rst),
        .enc_start  (start),
        .enc_done   (done),
        .sram       (sram_bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [262144];
    int write_count = 0, bad_writes = 0, done_count = 0, first_wr_addr = -1, max_rd = 0;
    int n_tests = 0, n_fail = 0;

    int pr [4*NG], pg [4*NG], pb [4*NG];
    logic [15:0] exp_y [2*NG], exp_u [NG], exp_v [NG];

    function automatic bit addr_ok(input int a);
        return (a >= Y_B && a < Y_B + 2*NG) || (a >= U_B && a < U_B + NG) ||
               (a >= V_B && a < V_B + NG);
    endfunction

    // SRAM: registered read, data on the bus two cycles after the address cycle
    always @(posedge clk) begin
        int a;
        a = int'(sram_bus.SRAM_address);
        if (!rst && !sram_bus.SRAM_we_n) begin
            if (write_count == 0) first_wr_addr = a;
            write_count++;
            if (!addr_ok(a)) bad_writes++;
            mem[a] = sram_bus.SRAM_write_data;
        end else if (!rst && a >= RGB_B && a > max_rd) begin
            max_rd = a;
        end
        sram_bus.SRAM_read_data <= mem[a];
        if (done) done_count++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int clip(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    task automatic build_expect();
        int y [4], u [4], v [4];
        for (int k = 0; k < NG; k++) begin
            for (int j = 0; j < 4; j++) begin
                int r, g, b;
                r = pr[4*k+j]; g = pg[4*k+j]; b = pb[4*k+j];
                y[j] = clip(16  + ((16829*r + 33039*g + 6416*b + 32768) >>> 16));
                u[j] = clip(128 + ((-9714*r - 19070*g + 28784*b + 32768) >>> 16));
                v[j] = clip(128 + ((28784*r - 24103*g - 4681*b + 32768) >>> 16));
            end
            exp_y[2*k]   = {8'(y[0]), 8'(y[1])};
            exp_y[2*k+1] = {8'(y[2]), 8'(y[3])};
            exp_u[k] = {8'((u[0] + u[1] + 1) / 2), 8'((u[2] + u[3] + 1) / 2)};
            exp_v[k] = {8'((v[0] + v[1] + 1) / 2), 8'((v[2] + v[3] + 1) / 2)};
        end
    endtask

    task automatic load_frame();
        for (int p = 0; p < 4*NG; p++) begin
            pr[p] = int'($urandom_range(0, 255));
            pg[p] = int'($urandom_range(0, 255));
            pb[p] = int'($urandom_range(0, 255));
        end
        for (int p = 0; p < 4; p++) begin pr[p] = 255; pg[p] = 255; pb[p] = 255; end
        for (int p = 4; p < 12; p++) begin pr[p] = 0; pg[p] = 0; pb[p] = 0; end
        pr[4] = 255; pr[5] = 255; pr[8] = 255;
        for (int k = 0; k < NG; k++) begin
            int q;
            q = 4*k;
            mem[RGB_B+6*k+0] = {8'(pr[q]),   8'(pg[q])};
            mem[RGB_B+6*k+1] = {8'(pb[q]),   8'(pr[q+1])};
            mem[RGB_B+6*k+2] = {8'(pg[q+1]), 8'(pb[q+1])};
            mem[RGB_B+6*k+3] = {8'(pr[q+2]), 8'(pg[q+2])};
            mem[RGB_B+6*k+4] = {8'(pb[q+2]), 8'(pr[q+3])};
            mem[RGB_B+6*k+5] = {8'(pg[q+3]), 8'(pb[q+3])};
        end
        for (int a = 0; a < 76800; a++) mem[a] = 16'hA5A5;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        int cycles;
        bit seen;
        load_frame();
        build_expect();

        // Reset held three cycles, with a start pulse that must be ignored
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check_eq("rst_we_n", sram_bus.SRAM_we_n, 1);
        check_eq("rst_addr", sram_bus.SRAM_address, 0);
        check_eq("rst_wdata", sram_bus.SRAM_write_data, 0);
        check_eq("rst_done", done, 0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("idle_addr", sram_bus.SRAM_address, 0);
        check_eq("idle_we_n", sram_bus.SRAM_we_n, 1);
        check_eq("idle_writes", write_count, 0);

        // Abort at group 500 state G6: the Y write of that cycle must not happen
        pulse_start();
        repeat (500*12 + 6 - 1) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 check_eq("abort_we_n", sram_bus.SRAM_we_n, 1);
        cycles = write_count;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("abort_no_writes", write_count, cycles);
        check_eq("abort_y999", mem[999], exp_y[999]);
        check_eq("abort_y1000", mem[1000], 16'hA5A5);
        check_eq("abort_u500", mem[U_B+500], 16'hA5A5);
        check_eq("abort_no_done", done_count, 0);

        // Full frame after restart
        write_count = 0;
        max_rd = 0;
        pulse_start();
        cycles = 1;
        seen = 1'b0;
        #1 if (done) seen = 1'b1;
        while (!seen && cycles < NG*12 + 100) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
            else cycles++;
        end
        check_eq("done_seen", seen, 1);
        check_eq("frame_cycles", cycles, NG*12);
        @(posedge clk);
        #1 check_eq("done_pulse_width", done, 0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("done_count", done_count, 1);
        check_eq("first_write_addr", first_wr_addr, Y_B);
        check_eq("write_count", write_count, 4*NG);
        check_eq("bad_writes", bad_writes, 0);
        check_eq("last_rgb_read", max_rd, RGB_B + 6*NG - 1);
        check_eq("final_we_n", sram_bus.SRAM_we_n, 1);

        check_eq("white_y0", mem[Y_B+0], 16'hEBEB);
        check_eq("white_y1", mem[Y_B+1], 16'hEBEB);
        check_eq("white_u", mem[U_B+0], 16'h8080);
        check_eq("white_v", mem[V_B+0], 16'h8080);
        check_eq("rrkk_y0", mem[Y_B+2], 16'h5151);
        check_eq("rrkk_y1", mem[Y_B+3], 16'h1010);
        check_eq("rrkk_u", mem[U_B+1], 16'h5A80);
        check_eq("rrkk_v", mem[V_B+1], 16'hF080);
        check_eq("rkkk_y0", mem[Y_B+4], 16'h5110);
        check_eq("rkkk_y1", mem[Y_B+5], 16'h1010);
        check_eq("rkkk_u", mem[U_B+2], 16'h6D80);
        check_eq("rkkk_v", mem[V_B+2], 16'hB880);

        for (int k = 0; k < NG; k++) begin
            check_eq($sformatf("y[%0d]", 2*k),   mem[Y_B+2*k],   exp_y[2*k]);
            check_eq($sformatf("y[%0d]", 2*k+1), mem[Y_B+2*k+1], exp_y[2*k+1]);
            check_eq($sformatf("u[%0d]", k),     mem[U_B+k],     exp_u[k]);
            check_eq($sformatf("v[%0d]", k),     mem[V_B+k],     exp_v[k]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
